mult_div_unit: RTL and testbench

- Multicycle signed multiply/divide engine that produces the values written into the HI/LO registers for mult and div instructions.
- Sits beside the ALU. The control unit launches an operation with a one-cycle start and waits on done; the block then sequences WIDTH shift/add (mult) or shift/subtract (div) iterations.
- Operands come from registers A and B. hi_out/lo_out feed the HI/LO registers, which are written under hi_w/lo_w.
- div_zero feeds the control unit's exception path.

---
 rtl/mult_div_unit.sv | 153 +++++++++++++++
 tb/tb_mult_div_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring, on magnitudes)
// engine producing the HI/LO register values for mult and div instructions.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MULT = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     mcand;
  // Booth accumulator {hi, lo, q-1}; hi carries one guard bit so that
  // subtracting a most-negative multiplicand cannot overflow.
  logic [2*WIDTH+1:0] acc;
  logic [WIDTH-1:0]   dvs;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;
  logic               neg_q;
  logic               neg_r;

  logic [WIDTH:0]     booth_hi;
  logic [2*WIDTH+1:0] acc_nxt;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   rem_sub;
  logic [WIDTH-1:0]   rem_nxt;
  logic [WIDTH-1:0]   quo_nxt;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               last_iter;

  always_comb begin
    booth_hi = acc[2*WIDTH+1:WIDTH+1];
    case (acc[1:0])
      2'b01:   booth_hi = booth_hi + mcand;
      2'b10:   booth_hi = booth_hi - mcand;
      default: booth_hi = acc[2*WIDTH+1:WIDTH+1];
    endcase
    acc_nxt = {booth_hi[WIDTH], booth_hi, acc[WIDTH:1]};
  end

  always_comb begin
    rem_sh  = {rem, quo[WIDTH-1]};
    rem_sub = rem_sh[WIDTH-1:0] - dvs;
    if (rem_sh >= {1'b0, dvs}) begin
      rem_nxt = rem_sub;
      quo_nxt = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt = rem_sh[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b0};
    end
  end

  // Unsigned magnitudes; |-2^(W-1)| = 2^(W-1) is representable unsigned.
  always_comb begin
    a_mag = a_in[WIDTH-1] ? (WIDTH'(0) - a_in) : a_in;
    b_mag = b_in[WIDTH-1] ? (WIDTH'(0) - b_in) : b_in;
  end

  assign last_iter = (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      mcand    <= '0;
      acc      <= '0;
      dvs      <= '0;
      rem      <= '0;
      quo      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi_out   <= '0;
      lo_out   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt <= CW'(WIDTH);
            if (!op) begin
              state <= S_MULT;
              busy  <= 1'b1;
              mcand <= {a_in[WIDTH-1], a_in};
              acc   <= {{(WIDTH+1){1'b0}}, b_in, 1'b0};
            end else if (b_in != '0) begin
              state <= S_DIV;
              busy  <= 1'b1;
              dvs   <= b_mag;
              quo   <= a_mag;
              rem   <= '0;
              neg_q <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
              neg_r <= a_in[WIDTH-1];
            end else begin
              state    <= S_DONE;
              done     <= 1'b1;
              div_zero <= 1'b1;
            end
          end
        end
        S_MULT: begin
          acc <= acc_nxt;
          cnt <= cnt - CW'(1);
          if (last_iter) begin
            hi_out   <= acc_nxt[2*WIDTH:WIDTH+1];
            lo_out   <= acc_nxt[WIDTH:1];
            state    <= S_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            div_zero <= 1'b0;
          end
        end
        S_DIV: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt - CW'(1);
          if (last_iter) begin
            lo_out   <= neg_q ? (WIDTH'(0) - quo_nxt) : quo_nxt;
            hi_out   <= neg_r ? (WIDTH'(0) - rem_nxt) : rem_nxt;
            state    <= S_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            div_zero <= 1'b0;
          end
        end
        S_DONE: begin
          state    <= S_IDLE;
          done     <= 1'b0;
          div_zero <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: transaction-level reference model
// compared every cycle, plus directed vectors with hand-computed results.
module tb_mult_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] hi_out, lo_out;

  int checks = 0;
  int failures = 0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .div_zero(div_zero),
    .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: inputs change only at posedge+1, so at each negedge the
  // model first checks the outputs, then predicts the effect of the next edge.
  int           m_left = 0;
  bit           m_done = 1'b0;
  bit           m_dz = 1'b0;
  bit           m_valid = 1'b0;
  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  longint       sa, sb, mq, mr;
  logic [63:0]  prod;

  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", busy, m_left > 0);
      chk("done", done, m_done);
      chk("div_zero", div_zero, m_dz);
      chk("hi_out", hi_out, m_hi);
      chk("lo_out", lo_out, m_lo);
    end
    if (!reset) begin
      m_left = 0; m_done = 1'b0; m_dz = 1'b0; m_hi = '0; m_lo = '0; m_valid = 1'b1;
    end else if (m_done) begin
      m_done = 1'b0; m_dz = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1'b1; m_hi = p_hi; m_lo = p_lo;
      end
    end else if (start === 1'b1) begin
      sa = $signed(a_in);
      sb = $signed(b_in);
      if (!op) begin
        prod = sa * sb;
        p_hi = prod[63:32]; p_lo = prod[31:0]; m_left = W;
      end else if (sb == 0) begin
        m_done = 1'b1; m_dz = 1'b1;
      end else begin
        mq = sa / sb; mr = sa % sb;
        p_lo = mq[31:0]; p_hi = mr[31:0]; m_left = W;
      end
    end
  end

  task automatic launch(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk); #1;
    start = 1'b1; op = o; a_in = a; b_in = b;
    @(posedge clk); #1;
    start = 1'b0; op = 1'($urandom); a_in = $urandom; b_in = $urandom;
  endtask

  task automatic wait_done(input int bound, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < bound);
    if (done !== 1'b1) begin
      checks++; failures++;
      $display("FAIL wait_done: no done within %0d cycles", n);
    end
  endtask

  task automatic run(input string name, input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                     input int lat, input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edz);
    int n;
    launch(o, a, b);
    wait_done(40, n);
    chk({name, "_latency"}, n, lat);
    chk({name, "_hi"}, hi_out, ehi);
    chk({name, "_lo"}, lo_out, elo);
    chk({name, "_dz"}, div_zero, edz);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'h8000_0000;
      2: return 32'h7FFF_FFFF;
      3: return 32'hFFFF_FFFF;
      4: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n, nd;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("reset_hi", hi_out, 0);
    chk("reset_busy", busy, 0);

    run("mul_7x-3", 1'b0, 32'd7, 32'hFFFF_FFFD, 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run("mul_min2", 1'b0, 32'h8000_0000, 32'h8000_0000, 33, 32'h4000_0000, 32'h0, 1'b0);
    run("mul_max2", 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 33, 32'h3FFF_FFFF, 32'h1, 1'b0);
    run("div_-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run("div_7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33, 32'h1, 32'hFFFF_FFFD, 1'b0);
    run("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0, 32'h8000_0000, 1'b0);
    run("div_451/20", 1'b1, 32'h451, 32'h20, 33, 32'h11, 32'h22, 1'b0);
    run("div_5/0", 1'b1, 32'd5, 32'd0, 1, 32'h11, 32'h22, 1'b1);
    @(negedge clk);
    chk("div0_clear", div_zero, 0);

    // start held through DONE: only one operation may result
    @(posedge clk); #1;
    start = 1'b1; op = 1'b0; a_in = 32'd3; b_in = 32'd5;
    nd = 0;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk); #1;
      if (i == 33) start = 1'b0;
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    chk("held_start_ops", nd, 1);
    chk("held_start_lo", lo_out, 15);

    // operands changing mid-operation must not matter
    launch(1'b0, 32'd3, 32'hFFFF_FFFB);
    repeat (4) @(posedge clk);
    #1 a_in = 32'h1234_5678; b_in = 32'h0BAD_F00D;
    wait_done(40, n);
    chk("latched_hi", hi_out, 32'hFFFF_FFFF);
    chk("latched_lo", lo_out, 32'hFFFF_FFF1);

    // reset at iteration 10 aborts without a done pulse
    launch(1'b0, 32'd123, 32'd456);
    repeat (9) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_lo", lo_out, 0);
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    chk("abort_no_done", nd, 0);
    run("mul_3x4", 1'b0, 32'd3, 32'd4, 33, 32'h0, 32'd12, 1'b0);

    for (int i = 0; i < 150; i++) begin
      launch(1'($urandom), pick(), pick());
      wait_done(40, n);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
